screen_sequencer: RTL
=====================

// Module: screen_sequencer
// PURPOSE
//  Top-level game-flow FSM for Frogger. Sequences the full-screen bitmap overlays
//  (start, game-won, game-over) against live play: counts lives and filled homes,
//  holds end screens for a fixed number of frames, and blinks the start screen.
//  Sits between the VGA timing block, the gameplay logic and the overlay bitmap ROMs.
//  Muxes their per-pixel flags into one registered overlay pixel.
// PARAMETERS
//  LIVES         3    lives at new game; 1..7
//  HOMES         5    homes to fill for a win; 1..7
//  HOLD_FRAMES   300  frames WON/LOST screen is held before returning to IDLE; >=1
//  BLINK_FRAMES  30   frames per blink half-period of the start screen; >=1
// PORTS
//  clk          in   1  pixel clock; all logic on rising edge
//  rst_n        in   1  synchronous reset, active low
//  frame_tick   in   1  one-cycle pulse per frame (start of vblank)
//  start_btn    in   1  debounced start button, level
//  frog_home    in   1  one-cycle pulse: frog reached an empty home
//  frog_dead    in   1  one-cycle pulse: frog killed
//  start_flag   in   1  start-screen ROM bit for current pixel
//  won_flag     in   1  game-won ROM bit for current pixel
//  over_flag    in   1  game-over ROM bit for current pixel
//  state        out  2  00 IDLE, 01 PLAY, 10 WON, 11 LOST
//  game_run     out  1  1 iff state==PLAY
//  lives        out  3  lives remaining
//  homes        out  3  homes filled this game
//  new_game     out  1  one-cycle pulse on IDLE/WON/LOST -> PLAY
//  overlay_pix  out  1  registered overlay pixel, 1 = draw
// BEHAVIOUR
//  Reset (rst_n=0 at edge):
//  - state=IDLE, lives=LIVES, homes=0, new_game=0, overlay_pix=0
//  - hold_cnt=0, blink_cnt=0, blink_on=1; start_prev=1 (a held button never auto-starts)
//  Reset mid-game aborts to IDLE in the same edge; no pending events survive.
//  start_rise = start_btn & ~start_prev; start_prev registers start_btn every cycle.
//  IDLE:
//  - start_rise -> PLAY; new_game=1 for one cycle; lives<=LIVES, homes<=0
//  PLAY:
//  - frog_dead & lives==1 -> LOST, lives<=0
//  - frog_dead & lives>1 -> lives-1, stay
//  - else frog_home & homes==HOMES-1 -> WON, homes<=HOMES
//  - else frog_home -> homes+1
//  - frog_dead and frog_home in same cycle: death wins, home ignored
//  - start_rise ignored in PLAY
//  frog_home/frog_dead ignored outside PLAY; no counter wraps.
//  WON/LOST:
//  - hold_cnt cleared on entry; increments on each frame_tick
//  - frame_tick with hold_cnt==HOLD_FRAMES-1 -> IDLE
//  - start_rise -> PLAY with new_game, same as IDLE, and has priority over timeout
//  - lives/homes hold their final values until next new game
//  Blink:
//  - on entry to IDLE: blink_cnt=0, blink_on=1
//  - in IDLE each frame_tick increments blink_cnt
//  - at BLINK_FRAMES-1: blink_cnt<=0, blink_on toggles
//  overlay_pix, registered, 1-cycle latency from flag inputs, uses current state:
//  - IDLE start_flag&blink_on; PLAY 0; WON won_flag; LOST over_flag
//  game_run decodes registered state; no extra latency.
// TESTING
//  1 Reset with start_btn=1 held -> stays IDLE; release, press -> PLAY, new_game 1 cycle, lives=3 homes=0
//  2 PLAY, 5 frog_home pulses -> homes 1..4 then state=WON, homes=5; won_flag=1 -> overlay_pix=1 next cycle
//  3 PLAY, 3 frog_dead pulses -> lives 2,1 then LOST lives=0; further dead/home pulses ignored
//  4 lives=1, homes=4, frog_home&frog_dead same cycle -> LOST, homes stays 4
//  5 WON, 300 frame_ticks -> IDLE on 300th; start_rise at tick 150 -> PLAY with lives=3 homes=0
//  6 IDLE, start_flag=1 -> overlay_pix 1 for 30 frames, 0 for 30, repeat; rst_n=0 mid-PLAY -> IDLE, all reset values

Source files
------------

// File: rtl/screen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : screen_sequencer
//  Description : Frogger game-flow FSM. Tracks lives and filled homes, holds
//                the won/lost screens for a fixed frame count, blinks the
//                start screen and muxes the overlay ROM bits into one
//                registered overlay pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module screen_sequencer #(
    parameter int LIVES        = 3,
    parameter int HOMES        = 5,
    parameter int HOLD_FRAMES  = 300,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick_i,
    input  logic       start_btn_i,
    input  logic       frog_home_i,
    input  logic       frog_dead_i,
    input  logic       start_flag_i,
    input  logic       won_flag_i,
    input  logic       over_flag_i,
    output logic [1:0] state_o,
    output logic       game_run_o,
    output logic [2:0] lives_o,
    output logic [2:0] homes_o,
    output logic       new_game_o,
    output logic       overlay_pix_o
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PLAY = 2'b01;
    localparam logic [1:0] S_WON  = 2'b10;
    localparam logic [1:0] S_LOST = 2'b11;

    localparam int HOLD_W  = (HOLD_FRAMES  > 1) ? $clog2(HOLD_FRAMES)  : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [2:0]         HOMES_LAST = 3'(HOMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [1:0]         state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [2:0]         homes_q, homes_d;
    logic               new_game_q, new_game_d;
    logic               overlay_q, overlay_d;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_on_q;
    logic               start_prev_q;

    logic start_rise;
    logic in_end_screen;
    logic hold_done;

    // Button edge: start_prev resets to 1 so a button held through reset never starts a game.
    assign start_rise    = start_btn_i & ~start_prev_q;
    assign in_end_screen = (state_q == S_WON) || (state_q == S_LOST);
    assign hold_done     = frame_tick_i && (hold_cnt_q == HOLD_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a death in PLAY masks a simultaneous home.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (frog_dead_i) begin
                    if (lives_q == 3'd1) state_d = S_LOST;
                end else if (frog_home_i && (homes_q == HOMES_LAST)) begin
                    state_d = S_WON;
                end
            end
            default: begin
                // Restart beats the hold timeout when both land on one edge.
                if (start_rise)     state_d = S_PLAY;
                else if (hold_done) state_d = S_IDLE;
            end
        endcase
    end

    // Output decode and next values of the registered outputs.
    always_comb begin
        state_o       = state_q;
        game_run_o    = (state_q == S_PLAY);
        lives_o       = lives_q;
        homes_o       = homes_q;
        new_game_o    = new_game_q;
        overlay_pix_o = overlay_q;

        lives_d    = lives_q;
        homes_d    = homes_q;
        new_game_d = 1'b0;
        if (state_q != S_PLAY) begin
            if (start_rise) begin
                lives_d    = LIVES_INIT;
                homes_d    = 3'd0;
                new_game_d = 1'b1;
            end
        end else if (frog_dead_i) begin
            lives_d = lives_q - 3'd1;
        end else if (frog_home_i) begin
            homes_d = homes_q + 3'd1;
        end

        case (state_q)
            S_IDLE:  overlay_d = start_flag_i & blink_on_q;
            S_PLAY:  overlay_d = 1'b0;
            S_WON:   overlay_d = won_flag_i;
            default: overlay_d = over_flag_i;
        endcase
    end

    // Game counters, pulse and pixel registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lives_q      <= LIVES_INIT;
            homes_q      <= 3'd0;
            new_game_q   <= 1'b0;
            overlay_q    <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            lives_q      <= lives_d;
            homes_q      <= homes_d;
            new_game_q   <= new_game_d;
            overlay_q    <= overlay_d;
            start_prev_q <= start_btn_i;
        end
    end

    // End-screen frame counter; held at zero outside WON/LOST so every entry starts clean.
    always_ff @(posedge clk) begin
        if (!rst_n || !in_end_screen) begin
            hold_cnt_q <= '0;
        end else if (frame_tick_i) begin
            hold_cnt_q <= (hold_cnt_q == HOLD_LAST) ? '0 : hold_cnt_q + 1'b1;
        end
    end

    // Start-screen blink; parked at phase 0 / visible while not IDLE so entry starts visible.
    always_ff @(posedge clk) begin
        if (!rst_n || (state_q != S_IDLE)) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (frame_tick_i) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_on_q  <= ~blink_on_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
